// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the write-back trace checker.
//   trace_entry_t        golden commit record {pc, wnum, wdata}, 69 bits
//   TRACE_END_PC_DEFAULT pc that marks end of test
//   st_e                 checker state encoding (RUN / DONE)
//   we_mask              expands a per-byte write enable into a 32-bit bit mask
package trace_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_entry_t;
    localparam logic [31:0] TRACE_END_PC_DEFAULT = 32'h1c000100;
    typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} st_e;
    function automatic logic [31:0] we_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of golden trace entries.
//   clk, reset   clock, synchronous active-high reset (clears pointers/count)
//   push, din    write din at the tail (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   head         entry at the head, valid when !empty
//   count        occupancy 0..DEPTH; full/empty flags derived from it
module trace_fifo import trace_pkg::*; #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t din,
    output trace_entry_t head,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    trace_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    always_comb begin
        full     = count_q == (AW+1)'(DEPTH);
        empty    = count_q == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head     = mem_q[rd_ptr_q];
        count    = count_q;
    end
    // Storage is not reset: entries are only ever read below the count.
    always_ff @(posedge clk) if (do_push) mem_q[wr_ptr_q] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/trace_checker.sv
// trace_checker: compares core write-back commits against a buffered golden trace.
//   clk, reset          clock, synchronous active-high reset
//   gold_*              golden entry valid/ready port from the trace loader
//   debug_wb_*          committed pc / byte write enable / register / data from the core
//   done                end-of-test pc seen (sticky)
//   err                 mismatch or underflow seen (sticky)
//   err_pc/_exp/_got    pc, expected data and masked core data at the first error
//   commit_cnt, err_cnt checked commits (wrapping) and errors (saturating)
//   fifo_count          golden FIFO occupancy
module trace_checker import trace_pkg::*; #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = TRACE_END_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gold_valid,
    output logic                      gold_ready,
    input  logic [31:0]               gold_pc,
    input  logic [4:0]                gold_wnum,
    input  logic [31:0]               gold_wdata,
    input  logic [31:0]               debug_wb_pc,
    input  logic [3:0]                debug_wb_rf_we,
    input  logic [4:0]                debug_wb_rf_wnum,
    input  logic [31:0]               debug_wb_rf_wdata,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               err_pc,
    output logic [31:0]               err_exp_wdata,
    output logic [31:0]               err_got_wdata,
    output logic [31:0]               commit_cnt,
    output logic [15:0]               err_cnt,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    st_e          state_q, state_d;
    trace_entry_t head;
    logic         full, empty, push, pop, commit, hit, err_now, first;
    logic [31:0]  m;
    logic         err_q, err_d;
    logic [31:0]  err_pc_q, err_pc_d, err_exp_q, err_exp_d, err_got_q, err_got_d;
    logic [31:0]  commit_cnt_q, commit_cnt_d;
    logic [15:0]  err_cnt_q, err_cnt_d;
    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata}),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) state_q <= reset ? ST_RUN : state_d;
    always_comb state_d = (state_q == ST_RUN && debug_wb_pc == END_PC) ? ST_DONE : state_q;
    // No push-through when full: ready depends only on state and occupancy.
    always_comb begin
        gold_ready = !reset && state_q == ST_RUN && !full;
        done       = state_q == ST_DONE;
    end
    always_comb begin
        push         = gold_valid && gold_ready;
        commit       = debug_wb_rf_we != '0 && debug_wb_rf_wnum != '0 && state_q == ST_RUN;
        pop          = commit && !empty;
        m            = we_mask(debug_wb_rf_we);
        hit          = !empty && debug_wb_pc == head.pc && debug_wb_rf_wnum == head.wnum &&
                       (debug_wb_rf_wdata & m) == (head.wdata & m);
        err_now      = commit && !hit;
        first        = err_now && !err_q;
        err_d        = err_q || err_now;
        commit_cnt_d = commit ? commit_cnt_q + 32'd1 : commit_cnt_q;
        err_cnt_d    = (err_now && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        err_pc_d     = first ? debug_wb_pc : err_pc_q;
        err_exp_d    = first ? (empty ? 32'd0 : head.wdata) : err_exp_q;
        err_got_d    = first ? (debug_wb_rf_wdata & m) : err_got_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q        <= 1'b0;
            err_pc_q     <= '0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
            commit_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            err_q        <= err_d;
            err_pc_q     <= err_pc_d;
            err_exp_q    <= err_exp_d;
            err_got_q    <= err_got_d;
            commit_cnt_q <= commit_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
    assign err           = err_q;
    assign err_pc        = err_pc_q;
    assign err_exp_wdata = err_exp_q;
    assign err_got_wdata = err_got_q;
    assign commit_cnt    = commit_cnt_q;
    assign err_cnt       = err_cnt_q;
endmodule
